// File: rtl/user_uart_rx.sv
// rtl/user_uart_rx.sv - 8N1 UART receiver feeding a byte FIFO read over a simple bus slave
`timescale 1ns/1ps
module user_uart_rx #(
  parameter int UART_RX_CLK_DIV = 434,
  parameter int FIFO_AW         = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_uart_rx,
  input  logic        bus_rd_req,
  output logic        bus_rd_gnt,
  input  logic [31:0] bus_rd_addr,
  output logic [31:0] bus_rd_data,
  input  logic        bus_wr_req,
  output logic        bus_wr_gnt,
  input  logic [31:0] bus_wr_addr,
  input  logic [31:0] bus_wr_data,
  input  logic [3:0]  bus_wr_be
);

  localparam int CW    = $clog2(UART_RX_CLK_DIV);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0] CNT_HALF = CW'(UART_RX_CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(UART_RX_CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         sync_q, sync_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]         head_q, head_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic [7:0]         fifo_mem [DEPTH];

  logic               rx_s, rx_prev;
  logic               push, pop, set_ferr, set_ovr;
  logic               empty, full, rd_hit, clr_wr;
  logic [FIFO_AW:0]   fifo_len;
  logic               unused_bits;

  // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection
  assign rx_s    = sync_q[1];
  assign rx_prev = sync_q[2];

  assign fifo_len   = wr_ptr_q - rd_ptr_q;
  assign empty      = (fifo_len == '0);
  assign full       = fifo_len[FIFO_AW];
  assign bus_rd_gnt = bus_rd_req;
  assign bus_wr_gnt = bus_wr_req;
  assign bus_rd_data = rd_data_q;
  assign rd_hit     = bus_rd_req && (bus_rd_addr[31:3] == 29'h0);
  assign clr_wr     = bus_wr_req && (bus_wr_addr[31:3] == 29'h0) && bus_wr_addr[2] && bus_wr_be[0];
  assign unused_bits = ^{bus_rd_addr[1:0], bus_wr_addr[1:0], bus_wr_data[31:2], bus_wr_be[3:1]};

  // Receive FSM: start-bit qualification at mid-bit, then one sample per bit period
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    set_ferr  = 1'b0;
    set_ovr   = 1'b0;
    sync_d    = {sync_q[1:0], i_uart_rx};
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rx_s)     set_ferr = 1'b1;
          else if (full) set_ovr  = 1'b1;
          else           push     = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FIFO pointers, prefetched head byte, sticky flags and registered bus read data
  always_comb begin
    pop         = rd_hit && !bus_rd_addr[2] && !empty;
    wr_ptr_d    = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
    // Write-through when the incoming byte lands on the slot that becomes the head
    if (push && (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_d[FIFO_AW-1:0]))
      head_d = shift_q;
    else
      head_d = fifo_mem[rd_ptr_d[FIFO_AW-1:0]];
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (clr_wr && bus_wr_data[0]) frame_err_d = 1'b0;
    if (clr_wr && bus_wr_data[1]) overrun_d   = 1'b0;
    if (set_ferr) frame_err_d = 1'b1;
    if (set_ovr)  overrun_d   = 1'b1;
    rd_data_d = '0;
    if (rd_hit) begin
      if (!bus_rd_addr[2]) begin
        if (!empty) rd_data_d = {23'h0, 1'b1, head_q};
      end else begin
        rd_data_d = {14'h0, overrun_q, frame_err_q, {(15 - FIFO_AW){1'b0}}, fifo_len};
      end
    end
  end

  // State registers; synchroniser resets to the idle-high line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync_q      <= 3'b111;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      head_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      head_q      <= head_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // FIFO storage array, written at the stop-bit sample
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= shift_q;
  end

endmodule

// File: tb/tb_user_uart_rx.sv
// tb/tb_user_uart_rx.sv - self-checking bench for user_uart_rx
`timescale 1ns/1ps
module tb_user_uart_rx;
  localparam int DIV   = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        rd_req = 1'b0, wr_req = 1'b0;
  logic        rd_gnt, wr_gnt;
  logic [31:0] rd_addr = '0, rd_data, wr_addr = '0, wr_data = '0;
  logic [3:0]  wr_be = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic [31:0] exp_status;
    logic [31:0] exp_rx;
  } vec_t;

  logic [7:0] mq[$];
  bit         m_ferr = 0, m_ovr = 0;

  user_uart_rx #(.UART_RX_CLK_DIV(DIV), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .i_uart_rx(rx),
    .bus_rd_req(rd_req), .bus_rd_gnt(rd_gnt), .bus_rd_addr(rd_addr), .bus_rd_data(rd_data),
    .bus_wr_req(wr_req), .bus_wr_gnt(wr_gnt), .bus_wr_addr(wr_addr), .bus_wr_data(wr_data),
    .bus_wr_be(wr_be)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int idle);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (idle) @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    rd_req = 1'b1; rd_addr = addr;
    #1 check("rd_gnt", {31'h0, rd_gnt}, 32'h1);
    @(negedge clk);
    data = rd_data;
    rd_req = 1'b0; rd_addr = '0;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(name, d, exp);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    wr_req = 1'b1; wr_addr = addr; wr_data = data; wr_be = be;
    #1 check("wr_gnt", {31'h0, wr_gnt}, 32'h1);
    @(negedge clk);
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
  endtask

  function automatic void model_frame(input logic [7:0] b, input logic stop);
    if (!stop)                 m_ferr = 1;
    else if (mq.size() == DEPTH) m_ovr = 1;
    else                       mq.push_back(b);
  endfunction

  function automatic logic [31:0] model_status();
    return (32'(m_ovr) << 17) | (32'(m_ferr) << 16) | 32'(mq.size());
  endfunction

  function automatic logic [31:0] model_read();
    if (mq.size() == 0) return 32'h0;
    return 32'h100 | 32'(mq.pop_front());
  endfunction

  initial begin
    vec_t vecs[5];
    logic [31:0] d;
    vecs[0] = '{8'h55, 1'b1, 32'h1,     32'h155};
    vecs[1] = '{8'h00, 1'b1, 32'h1,     32'h100};
    vecs[2] = '{8'hFF, 1'b1, 32'h1,     32'h1FF};
    vecs[3] = '{8'h81, 1'b0, 32'h10000, 32'h0};
    vecs[4] = '{8'h7E, 1'b1, 32'h1,     32'h17E};

    repeat (3) @(negedge clk);
    check("reset_rd_data", rd_data, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    read_check("reset_status", 32'h4, 32'h0);
    read_check("reset_rxdata", 32'h0, 32'h0);

    // Basic frame, invalid addresses must not pop
    send_frame(8'h55, 1'b1, 2);
    read_check("b_status", 32'h4, 32'h1);
    read_check("b_bad_addr8", 32'h8, 32'h0);
    read_check("b_bad_addr_hi", 32'h100, 32'h0);
    read_check("b_status2", 32'h4, 32'h1);
    read_check("b_rx", 32'h0, 32'h155);
    read_check("b_status_empty", 32'h4, 32'h0);
    read_check("b_rx_empty", 32'h0, 32'h0);

    // Table of single frames
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, 4);
      read_check($sformatf("vec%0d_status", i), 32'h4, vecs[i].exp_status);
      read_check($sformatf("vec%0d_rx", i), 32'h0, vecs[i].exp_rx);
      if (vecs[i].exp_status[16]) begin
        bus_write(32'h4, 32'h1, 4'h0);
        read_check($sformatf("vec%0d_noclear_be0", i), 32'h4, 32'h10000);
        bus_write(32'h4, 32'h1, 4'h1);
      end
      read_check($sformatf("vec%0d_status_after", i), 32'h4, 32'h0);
    end

    // Back-to-back frames with no idle gap
    send_frame(8'hA5, 1'b1, 0);
    send_frame(8'h3C, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 4);
    read_check("b2b_status", 32'h4, 32'h3);
    read_check("b2b_rx0", 32'h0, 32'h1A5);
    read_check("b2b_rx1", 32'h0, 32'h13C);
    read_check("b2b_rx2", 32'h0, 32'h1FF);

    // Short low glitch must be rejected
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    read_check("glitch_status", 32'h4, 32'h0);
    send_frame(8'h5A, 1'b1, 2);
    read_check("glitch_after_rx", 32'h0, 32'h15A);

    // Overrun: five frames into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 2);
    read_check("ovr_status", 32'h4, 32'h20004);
    for (int i = 1; i <= 4; i++) read_check($sformatf("ovr_rx%0d", i), 32'h0, 32'h100 | 32'(i));
    read_check("ovr_rx_empty", 32'h0, 32'h0);
    bus_write(32'h4, 32'h2, 4'h1);
    read_check("ovr_cleared", 32'h4, 32'h0);

    // Reset in the middle of a frame, with a byte already queued
    send_frame(8'h99, 1'b1, 2);
    rx = 1'b0;
    repeat (DIV * 4 + DIV / 2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_rd_data", rd_data, 32'h0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    read_check("midrst_status", 32'h4, 32'h0);
    send_frame(8'h42, 1'b1, 2);
    read_check("midrst_status2", 32'h4, 32'h1);
    read_check("midrst_rx", 32'h0, 32'h142);

    // Randomised traffic against the queue model
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic       st;
      int         idle, nrd;
      b    = 8'($urandom);
      st   = ($urandom_range(0, 7) != 0);
      idle = st ? int'($urandom_range(0, 6)) : int'($urandom_range(2, 6));
      send_frame(b, st, idle);
      model_frame(b, st);
      nrd = $urandom_range(0, 2);
      for (int k = 0; k < nrd; k++) begin
        bus_read(32'($urandom_range(0, 3)), d);
        check("rand_rx", d, model_read());
      end
      if ($urandom_range(0, 2) == 0) begin
        bus_read(32'h4 | 32'($urandom_range(0, 3)), d);
        check("rand_status", d, model_status());
      end
      if ($urandom_range(0, 4) == 0) begin
        logic [1:0] c;
        c = 2'($urandom);
        bus_write(32'h4, {30'h0, c}, 4'h1);
        if (c[0]) m_ferr = 0;
        if (c[1]) m_ovr  = 0;
      end
    end
    read_check("rand_final_status", 32'h4, model_status());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/user_uart_rx.md
Name: user_uart_rx

Overview:
UART receiver that consumes the serial stream produced by a user_uart_tx on the far end of the line. It deserialises 8N1 frames from o_uart_tx-style traffic into a byte FIFO, and exposes that FIFO to the CPU over a naive_bus slave port. It is the read-side counterpart of the TX block and sits on the same bus segment.

Parameters:
UART_RX_CLK_DIV, 434, clock cycles per bit (115200 baud at 50 MHz); must be >= 4
FIFO_AW, 10, FIFO address width; depth = 2**FIFO_AW bytes

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
i_uart_rx  input  1  serial RX line, asynchronous to clk, idle high
bus  naive_bus.slave  -  bus slave interface: rd_req, rd_gnt, rd_addr[31:0], rd_data[31:0], wr_req, wr_gnt, wr_addr[31:0], wr_data[31:0], wr_be[3:0]

Behaviour:
- Reset: all flops clear asynchronously on rst high.
  - bus.rd_data = 0, FIFO pointers = 0, flags = 0, FSM = IDLE.
  - Synchroniser flops reset to 1 (line idle).
- Input sync: 2-FF synchroniser on i_uart_rx gives rx_s. A third flop holds rx_s_d for edge detection.
- Bit counter cnt: 0..UART_RX_CLK_DIV-1, reset to 0 on every state entry.
- FSM:
  - IDLE: on falling edge (rx_s_d=1, rx_s=0) -> START.
  - START: at cnt == UART_RX_CLK_DIV/2-1, sample rx_s.
    - 0 -> DATA with bit_idx=0.
    - 1 -> IDLE (glitch rejected, nothing recorded).
  - DATA: at cnt == UART_RX_CLK_DIV-1, shift in LSB-first: shift <= {rx_s, shift[7:1]}; bit_idx++. After the 8th bit -> STOP.
  - STOP: at cnt == UART_RX_CLK_DIV-1, sample rx_s.
    - 1: push shift into FIFO; if FIFO is full, drop the byte and set overrun.
    - 0: drop the byte and set frame_err.
    - Either way -> IDLE.
    - A held-low line (break) does not retrigger, because IDLE needs a falling edge.
- FIFO:
  - Pointers are FIFO_AW+1 bits; fifo_len = wr_ptr - rd_ptr, modulo wrap.
  - empty when fifo_len == 0; full when fifo_len == 2**FIFO_AW.
  - Push is written at the STOP sample edge; the byte is visible to a read from the next cycle.
  - Push and pop in the same cycle both take effect; fifo_len is unchanged.
- Bus read:
  - bus.rd_gnt = bus.rd_req (combinational, always granted).
  - bus.rd_data is registered and valid the cycle after rd_req. It is 0 for invalid addresses and when no read is requested.
  - Address decode uses rd_addr[31:3]==0 and rd_addr[2].
  - 0x0 RXDATA: returns {23'h0, ~empty, head_byte}.
    - If non-empty, rd_ptr increments (pop).
    - If empty, returns 0 with no pop.
    - FIFO storage is a registered-read RAM; head_byte must match the byte popped, so the implementation keeps a prefetched head register or an equivalent.
  - 0x4 STATUS: returns {14'h0, overrun, frame_err, (16-FIFO_AW-1)'h0, fifo_len}. No side effects.
- Bus write:
  - bus.wr_gnt = bus.wr_req (always granted).
  - A write to 0x4 with wr_be[0]: wr_data[0]=1 clears frame_err, wr_data[1]=1 clears overrun.
  - A flag set and a clear in the same cycle: set wins.
  - Writes to other addresses are ignored.
- Reset mid-frame: the frame is abandoned and the FSM returns to IDLE. A frame partially present when rst deasserts is captured only if a fresh falling edge occurs.

Test Plan:
- CLK_DIV=8: send frame 0x55 with correct stop bit -> STATUS fifo_len=1; RXDATA read returns 0x155; next STATUS fifo_len=0; next RXDATA returns 0x000.
- Send 0xA5, 0x3C, 0xFF back-to-back, zero idle between frames -> three reads return 0x1A5, 0x13C, 0x1FF in order; frame_err=0.
- Frame 0x81 with stop bit driven 0 -> fifo_len stays 0; STATUS bit16=1; write 0x1 to 0x4 clears it to 0.
- 2-cycle low glitch on idle line (CLK_DIV=8) -> no byte, no flags, FSM back to IDLE.
- FIFO_AW=2: send 5 frames 0x01..0x05 without reading -> fifo_len=4, overrun=1; reads return 0x101..0x104; 0x05 is lost.
- Assert rst during the 4th data bit, release, then send 0x42 -> only 0x42 is received, fifo_len=1, flags=0.
